// File: rtl/corona_tx.sv
// corona_tx: streams the 7-bit ASCII keyword "CORONA" over valid/ready, repeated count times per start.
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   start      send request, sampled only in IDLE
//   count      words to send, latched when start is accepted
//   abort      synchronous cancel, honoured outside IDLE/FIN
//   out_data   current character (0 outside character states)
//   out_valid  out_data holds a character
//   out_ready  sink accepts this cycle
//   out_last   marks the final 'A' of each word
//   busy       high while a transfer is in progress
//   done       one-cycle pulse at normal completion
module corona_tx #(
  parameter int CW  = 4,
  parameter int GAP = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [CW-1:0] count,
  input  logic          abort,
  output logic [6:0]    out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_last,
  output logic          busy,
  output logic          done
);
  localparam int GW = (GAP > 1) ? $clog2(GAP + 1) : 1;
  typedef enum logic [3:0] {S_IDLE, S_TC, S_TO1, S_TR, S_TO2, S_TN, S_TA, S_GAP, S_FIN} state_t;
  state_t        state, state_d;
  logic [CW-1:0] words, words_d;
  logic [GW-1:0] gap_cnt, gap_d;
  logic          hs;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state   <= S_IDLE;
      words   <= '0;
      gap_cnt <= '0;
    end else begin
      state   <= state_d;
      words   <= words_d;
      gap_cnt <= gap_d;
    end
  // Outputs decode from the registered state only, so out_ready never reaches an output.
  always_comb begin
    out_valid = state inside {S_TC, S_TO1, S_TR, S_TO2, S_TN, S_TA};
    out_last  = state == S_TA;
    busy      = out_valid || state == S_GAP;
    done      = state == S_FIN;
    case (state)
      S_TC:         out_data = 7'h43;
      S_TO1, S_TO2: out_data = 7'h4F;
      S_TR:         out_data = 7'h52;
      S_TN:         out_data = 7'h4E;
      S_TA:         out_data = 7'h41;
      default:      out_data = 7'h00;
    endcase
  end
  always_comb begin
    state_d = state;
    words_d = words;
    gap_d   = gap_cnt;
    hs      = out_valid && out_ready;
    case (state)
      S_IDLE: if (start) begin
        words_d = count;
        state_d = (count != '0) ? S_TC : S_FIN;
      end
      S_TC:  if (hs) state_d = S_TO1;
      S_TO1: if (hs) state_d = S_TR;
      S_TR:  if (hs) state_d = S_TO2;
      S_TO2: if (hs) state_d = S_TN;
      S_TN:  if (hs) state_d = S_TA;
      S_TA: if (hs) begin
        words_d = words - 1'b1;
        if (words == CW'(1)) state_d = S_FIN;
        else if (GAP == 0) state_d = S_TC;
        else begin
          gap_d   = GW'(GAP);
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        gap_d   = gap_cnt - 1'b1;
        state_d = (gap_cnt == GW'(1)) ? S_TC : S_GAP;
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Abort wins over a simultaneous handshake and drops the partial word.
    if (abort && state != S_IDLE && state != S_FIN) begin
      state_d = S_IDLE;
      words_d = '0;
      gap_d   = '0;
    end
  end
endmodule
